// File: rtl/fcmp_vec.sv
// Pipelined vector FP compare: LANES x 64-bit lanes (one double or two singles each),
// per-element predicate mask, element-0 flags, sticky invalid. Optional FCMP_VEC_FIRST_EN adds first_idx/first_has.
module fcmp_vec #(
    parameter int LANES  = 2,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [64*LANES-1:0]    A,
    input  logic [64*LANES-1:0]    B,
    input  logic                   isDbl,
    input  logic                   ord,
    input  logic [2:0]             cmod,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*LANES-1:0]     mask,
    output logic [5:0]             flags,
    output logic                   inv,
    output logic                   inv_sticky,
    input  logic                   clr_inv
`ifdef FCMP_VEC_FIRST_EN
    ,
    output logic [((2*LANES > 2) ? $clog2(2*LANES) : 1)-1:0] first_idx,
    output logic                   first_has
`endif
);

    localparam int NE = 2 * LANES;
`ifdef FCMP_VEC_FIRST_EN
    localparam int FW = (NE > 2) ? $clog2(NE) : 1;
`endif

    typedef struct packed {
        logic un;
        logic eq;
        logic lt;
        logic snan;
    } elem_t;

    typedef struct packed {
        logic [NE-1:0] mask;
        logic [5:0]    flags;
        logic          inv;
`ifdef FCMP_VEC_FIRST_EN
        logic [FW-1:0] first_idx;
        logic          first_has;
`endif
    } res_t;

    // Singles arrive zero-extended in the low 32 bits; dbl selects which field layout applies.
    function automatic elem_t cmp_elem(input logic [63:0] a, input logic [63:0] b, input logic dbl);
        logic        a_sgn, b_sgn, a_nan, b_nan, a_q, b_q, mag_lt;
        logic [62:0] a_mag, b_mag;
        elem_t       r;
        a_sgn  = dbl ? a[63] : a[31];
        b_sgn  = dbl ? b[63] : b[31];
        a_mag  = dbl ? a[62:0] : {32'b0, a[30:0]};
        b_mag  = dbl ? b[62:0] : {32'b0, b[30:0]};
        a_nan  = (dbl ? &a[62:52] : &a[30:23]) & (dbl ? |a[51:0] : |a[22:0]);
        b_nan  = (dbl ? &b[62:52] : &b[30:23]) & (dbl ? |b[51:0] : |b[22:0]);
        a_q    = dbl ? a[51] : a[22];
        b_q    = dbl ? b[51] : b[22];
        r.un   = a_nan | b_nan;
        r.snan = (a_nan & ~a_q) | (b_nan & ~b_q);
        r.eq   = ~r.un & (((a_mag == '0) & (b_mag == '0)) | ((a_sgn == b_sgn) & (a_mag == b_mag)));
        if (a_sgn != b_sgn) mag_lt = a_sgn;
        else                mag_lt = a_sgn ? (a_mag > b_mag) : (a_mag < b_mag);
        r.lt   = ~r.un & ~r.eq & mag_lt;
        return r;
    endfunction

    function automatic logic pred(input logic [2:0] c, input elem_t r);
        logic ge, p;
        ge = ~r.un & ~r.lt;
        case (c)
            3'd0:    p = ge;
            3'd1:    p = ~ge;
            3'd2:    p = r.un;
            3'd3:    p = ~r.un;
            3'd4:    p = r.eq;
            3'd5:    p = ~r.eq;
            3'd6:    p = r.lt;
            3'd7:    p = r.lt | r.eq;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    elem_t            elem_res [NE];
    res_t             res_new;
    logic [STAGES-1:0] vld_q, vld_d;
    res_t             pipe_q [STAGES];
    res_t             pipe_d [STAGES];
    logic             inv_sticky_q, inv_sticky_d;
    logic             stall;

    // NOTE: every variable in a combinational block gets a default first, so no latch can be inferred.
    always_comb begin
        res_new = '0;
        for (int l = 0; l < LANES; l++) begin
            if (isDbl) begin
                elem_res[2*l]   = cmp_elem(A[64*l +: 64], B[64*l +: 64], 1'b1);
                elem_res[2*l+1] = elem_res[2*l];
            end else begin
                elem_res[2*l]   = cmp_elem({32'b0, A[64*l +: 32]}, {32'b0, B[64*l +: 32]}, 1'b0);
                elem_res[2*l+1] = cmp_elem({32'b0, A[64*l+32 +: 32]}, {32'b0, B[64*l+32 +: 32]}, 1'b0);
            end
        end
        for (int e = 0; e < NE; e++) begin
            res_new.mask[e] = pred(cmod, elem_res[e]);
            res_new.inv     = res_new.inv | (ord ? elem_res[e].un : elem_res[e].snan);
        end
        res_new.flags = {~elem_res[0].un & ~elem_res[0].lt, elem_res[0].un, 1'b0,
                         elem_res[0].lt, elem_res[0].eq, elem_res[0].un};
`ifdef FCMP_VEC_FIRST_EN
        res_new.first_has = |res_new.mask;
        for (int e = NE - 1; e >= 0; e--) begin
            if (res_new.mask[e]) res_new.first_idx = FW'(e);
        end
`endif
    end

    assign stall    = vld_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    // The whole pipe moves together; bubbles advance like ops so latency is fixed.
    always_comb begin
        vld_d  = vld_q;
        pipe_d = pipe_q;
        if (!stall) begin
            vld_d[0]  = in_valid;
            pipe_d[0] = res_new;
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s]  = vld_q[s-1];
                pipe_d[s] = pipe_q[s-1];
            end
        end
        inv_sticky_d = inv_sticky_q;
        if (clr_inv)
            inv_sticky_d = 1'b0;
        else if (vld_q[STAGES-1] & out_ready & pipe_q[STAGES-1].inv)
            inv_sticky_d = 1'b1;
    end

    // NOTE: payload registers are reset too because the outputs come straight from the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            inv_sticky_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) pipe_q[s] <= '0;
        end else begin
            vld_q        <= vld_d;
            inv_sticky_q <= inv_sticky_d;
            pipe_q       <= pipe_d;
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign mask       = pipe_q[STAGES-1].mask;
    assign flags      = pipe_q[STAGES-1].flags;
    assign inv        = pipe_q[STAGES-1].inv;
    assign inv_sticky = inv_sticky_q;
`ifdef FCMP_VEC_FIRST_EN
    assign first_idx  = pipe_q[STAGES-1].first_idx;
    assign first_has  = pipe_q[STAGES-1].first_has;
`endif

endmodule
